// File: rtl/bus_pkg.sv
// Shared bus and UART definitions: command encoding, register offsets,
// STATUS/CTRL bit positions and the shifter state types.
package bus_pkg;

    typedef enum logic [1:0] {
        CMD_READ    = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_READ_B  = 2'd2,
        CMD_WRITE_B = 2'd3
    } bus_cmd_t;

    // Byte offsets of the UART registers (addr[0] is ignored).
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    localparam int unsigned ST_TX_FULL      = 0;
    localparam int unsigned ST_TX_EMPTY     = 1;
    localparam int unsigned ST_RX_VALID     = 2;
    localparam int unsigned ST_RX_OVERRUN   = 3;
    localparam int unsigned ST_TX_BUSY      = 4;
    localparam int unsigned ST_RX_FRAME_ERR = 5;

    localparam int unsigned CTRL_RX_IRQ_EN     = 0;
    localparam int unsigned CTRL_TXDONE_IRQ_EN = 1;
    localparam int unsigned CTRL_LOOPBACK      = 2;
    localparam int unsigned CTRL_W             = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic is_write(input bus_cmd_t c);
        return (c == CMD_WRITE) || (c == CMD_WRITE_B);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    assign dout = mem[rd_ptr];

    // Qualify requests against occupancy and work out the next count.
    always_comb begin
        do_push   = push & ~full;
        do_pop    = pop & ~empty;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and registered full/empty flags.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped UART on the toggle run/done CPU bus, with TX/RX FIFOs,
// STATUS/CTRL registers and a level interrupt.
// Optional build macro BUS_UART_LOOPBACK_EN adds CTRL bit 2 (internal loopback).
module bus_uart
    import bus_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 27000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [1:0]  cmd,
    input  logic        run,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        uart_txp,
    input  logic        uart_rxp,
    output logic        irq
);
    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(DIV / 2 - 1);

    logic run_m, run_s;
    logic pending, hit, wr, stall, complete;
    logic [2:0] off;
    logic tx_push, tx_pop, rx_pop, stat_rd;
    logic [15:0] status, rd_val;
    logic [CTRL_W-1:0] ctrl;
    logic rx_overrun, rx_frame_err;

    logic [7:0] tx_dout, rx_dout;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;

    tx_state_t tx_st;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_sh;
    logic tx_line, tx_busy;

    rx_state_t rx_st;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh;
    logic rx_line, rx_m, rx_s, rx_prev, rx_done, rx_ferr;

    logic unused_ok;
    assign unused_ok = ^{wr_data[15:8], addr[0], tx_count, rx_count};

`ifdef BUS_UART_LOOPBACK_EN
    assign rx_line  = ctrl[CTRL_LOOPBACK] ? tx_line : uart_rxp;
    assign uart_txp = tx_line | ctrl[CTRL_LOOPBACK];
`else
    assign rx_line  = uart_rxp;
    assign uart_txp = tx_line;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .sysclk(sysclk), .reset(reset), .push(tx_push), .din(wr_data[7:0]),
        .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .sysclk(sysclk), .reset(reset), .push(rx_done), .din(rx_sh),
        .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Synchronise the CPU run toggle and the serial input.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            run_m   <= 1'b0;
            run_s   <= 1'b0;
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            run_m   <= run;
            run_s   <= run_m;
            rx_m    <= rx_line;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // Decode the pending request; a DATA write into a full TX FIFO waits.
    always_comb begin
        pending  = (run_s != done);
        hit      = (addr[15:3] == BASE_ADDR[15:3]);
        off      = {addr[2:1], 1'b0};
        wr       = is_write(bus_cmd_t'(cmd));
        stall    = hit & wr & (off == OFF_DATA) & tx_full;
        complete = pending & ~stall;
        tx_push  = complete & hit & wr & (off == OFF_DATA);
        rx_pop   = complete & hit & ~wr & (off == OFF_DATA) & ~rx_empty;
        stat_rd  = complete & hit & ~wr & (off == OFF_STATUS);
        tx_busy  = (tx_st != TX_IDLE);
        tx_pop   = ~tx_empty & ((tx_st == TX_IDLE) | ((tx_st == TX_STOP) & (tx_cnt == CNT_LAST)));
    end

    // STATUS image and read-data mux.
    always_comb begin
        status                  = '0;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_VALID]     = ~rx_empty;
        status[ST_RX_OVERRUN]   = rx_overrun;
        status[ST_TX_BUSY]      = tx_busy;
        status[ST_RX_FRAME_ERR] = rx_frame_err;
        rd_val = 16'hFFFF;
        if (hit) begin
            case (off)
                OFF_DATA:   rd_val = rx_empty ? 16'h0000 : {8'h00, rx_dout};
                OFF_STATUS: rd_val = status;
                OFF_CTRL:   rd_val = 16'(ctrl);
                default:    rd_val = 16'hFFFF;
            endcase
        end
    end

    // Bus completion: done toggle, read data capture and CTRL writes.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            done    <= 1'b0;
            rd_data <= '0;
            ctrl    <= '0;
        end else if (complete) begin
            done <= ~done;
            if (!wr) begin
                rd_data <= rd_val;
            end else if (hit && off == OFF_CTRL) begin
`ifdef BUS_UART_LOOPBACK_EN
                ctrl <= wr_data[CTRL_W-1:0];
`else
                ctrl <= {1'b0, wr_data[1:0]};
`endif
            end
        end
    end

    // Sticky RX error flags; a new event wins over a STATUS-read clear.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (stat_rd) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
            end
            if (rx_done && rx_full) rx_overrun   <= 1'b1;
            if (rx_ferr)            rx_frame_err <= 1'b1;
        end
    end

    // Registered interrupt.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
                   (ctrl[CTRL_TXDONE_IRQ_EN] & tx_empty & ~tx_busy);
        end
    end

    // TX shifter: start, 8 data bits LSB first, stop; chains frames without a gap.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_st   <= TX_IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            tx_line <= 1'b1;
        end else begin
            case (tx_st)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_st   <= TX_START;
                        tx_cnt  <= '0;
                        tx_sh   <= tx_dout;
                        tx_line <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_st   <= TX_DATA;
                        tx_cnt  <= '0;
                        tx_bit  <= '0;
                        tx_line <= tx_sh[0];
                        tx_sh   <= {1'b0, tx_sh[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_st   <= TX_STOP;
                            tx_line <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_line <= tx_sh[0];
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_st   <= TX_START;
                            tx_sh   <= tx_dout;
                            tx_line <= 1'b0;
                        end else begin
                            tx_st <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // RX sampler: mid-bit sampling, false-start rejection, stop-bit check.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_st  <= RX_START;
                        rx_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CNT_MID) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                        else                rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        rx_st  <= RX_IDLE;
                        if (rx_s) rx_done <= 1'b1;
                        else      rx_ferr <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: random bytes through TX and RX, checked
// against a queue-based model of the FIFOs, flags and register map.
`timescale 1ns/1ps
module tb_bus_uart;
    localparam int unsigned DIV = 10;
    localparam int unsigned RXD = 8;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [1:0]  cmd;
    logic        run;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        done;
    logic        uart_txp;
    logic        uart_rxp;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;

    // Line monitor output and RX reference model.
    logic [7:0]  tx_got[$];
    int unsigned tx_t0[$];
    logic        tx_stop[$];
    logic [7:0]  rx_q[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;

    logic [7:0]  mon_b;
    int unsigned mon_t;
    logic        mon_start_ok;

    bus_uart #(
        .CLK_FREQ(1000000), .BAUD(100000), .TX_DEPTH(16), .RX_DEPTH(8), .BASE_ADDR(16'h0000)
    ) dut (
        .sysclk(sysclk), .reset(reset), .addr(addr), .cmd(cmd), .run(run),
        .wr_data(wr_data), .rd_data(rd_data), .done(done),
        .uart_txp(uart_txp), .uart_rxp(uart_rxp), .irq(irq)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decode frames seen on uart_txp by sampling mid-bit.
    initial begin
        forever begin
            @(negedge sysclk);
            if (uart_txp === 1'b0 && reset === 1'b0) begin
                mon_t = cyc;
                repeat (DIV / 2) @(negedge sysclk);
                mon_start_ok = (uart_txp === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge sysclk);
                    mon_b[i] = uart_txp;
                end
                repeat (DIV) @(negedge sysclk);
                tx_got.push_back(mon_b);
                tx_t0.push_back(mon_t);
                tx_stop.push_back(uart_txp & mon_start_ok);
            end
        end
    end

    task automatic bus_xfer(input logic [1:0] c, input logic [15:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
        @(negedge sysclk);
        cmd = c; addr = a; wr_data = wd; run = ~run;
        lat = 0;
        while (done !== run && lat < 400) begin
            @(posedge sysclk); #1;
            lat++;
        end
        if (done !== run) chk("done_timeout", 32'(done), 32'(run));
        rd = rd_data;
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [15:0] rd);
        int lat;
        bus_xfer(($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0, a, 16'($urandom), rd, lat);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [15:0] wd, output int lat);
        logic [15:0] rd;
        bus_xfer(($urandom_range(0, 1) != 0) ? 2'd3 : 2'd1, a, wd, rd, lat);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Drive one serial frame on uart_rxp and update the RX model.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge sysclk);
        uart_rxp = 1'b0;
        clocks(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rxp = b[i];
            clocks(DIV);
        end
        uart_rxp = stop_bit;
        clocks(DIV);
        uart_rxp = 1'b1;
        clocks(stop_bit ? 3 : DIV);
        if (stop_bit) begin
            if (rx_q.size() < RXD) rx_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    // Expected STATUS with the transmitter idle; reading clears the sticky flags.
    function automatic logic [15:0] exp_status();
        logic [15:0] s = 16'h0002;
        if (rx_q.size() != 0) s = s | 16'h0004;
        if (m_ovr)            s = s | 16'h0008;
        if (m_ferr)           s = s | 16'h0020;
        return s;
    endfunction

    task automatic chk_status(input string tag);
        logic [15:0] rd;
        logic [15:0] e;
        e = exp_status();
        rd_reg(16'h0002, rd);
        chk(tag, 32'(rd), 32'(e));
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic chk_data_pop(input string tag);
        logic [15:0] rd;
        logic [15:0] e;
        e = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'h0000;
        rd_reg(16'h0000, rd);
        chk(tag, 32'(rd), 32'(e));
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (tx_got.size() < n && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        if (tx_got.size() < n) chk("frame_timeout", 32'(tx_got.size()), 32'(n));
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  exp_tx[$];
        logic [7:0]  b;
        int          lat;
        int          lats[18];

        reset = 1'b1; run = 1'b0; addr = '0; cmd = '0; wr_data = '0; uart_rxp = 1'b1;
        clocks(3);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_txp", 32'(uart_txp), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        clocks(2);

        chk_status("status_idle");
        rd_reg(16'h0004, rd);
        chk("ctrl_reset", 32'(rd), 32'd0);

        // Single TX byte: three-cycle latency, correct framing, idle after.
        bus_xfer(2'd3, 16'h0000, 16'h0041, rd, lat);
        chk("tx_latency", 32'(lat), 32'd3);
        wait_frames(1, 300);
        if (tx_got.size() > 0) begin
            chk("tx_byte_41", 32'(tx_got[0]), 32'h41);
            chk("tx_frame_41", 32'(tx_stop[0]), 32'd1);
        end
        clocks(DIV + 2);
        chk_status("status_after_tx");
        tx_got.delete(); tx_t0.delete(); tx_stop.delete();

        // Burst of 18: the shifter holds one byte and the FIFO 16, so only the last stalls.
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom);
            exp_tx.push_back(b);
            wr_reg(16'h0000, {8'($urandom), b}, lat);
            lats[i] = lat;
        end
        chk("burst_17th_lat", 32'(lats[16]), 32'd3);
        chk("burst_18th_stall", 32'(lats[17] > 10), 32'd1);
        wait_frames(18, 2500);
        for (int i = 0; i < 18; i++) begin
            if (i < tx_got.size()) begin
                chk($sformatf("burst_byte%0d", i), 32'(tx_got[i]), 32'(exp_tx[i]));
                chk($sformatf("burst_frame%0d", i), 32'(tx_stop[i]), 32'd1);
                if (i > 0) chk($sformatf("burst_gap%0d", i), tx_t0[i] - tx_t0[i-1], 10 * DIV);
            end
        end
        clocks(DIV + 2);
        chk_status("status_after_burst");
        tx_got.delete(); tx_t0.delete(); tx_stop.delete();

        // RX single bytes, then read on an empty FIFO.
        send_rx(8'hA5, 1'b1);
        chk_status("status_rx_valid");
        chk_data_pop("rx_data_a5");
        chk_data_pop("rx_data_empty");
        for (int i = 0; i < 3; i++) begin
            send_rx(8'($urandom), 1'b1);
            chk_data_pop($sformatf("rx_rand%0d", i));
        end

        // Overrun: nine frames into an eight-entry FIFO.
        for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1);
        chk_status("status_overrun");
        chk_status("status_ovr_cleared");
        for (int i = 0; i < 9; i++) chk_data_pop($sformatf("drain%0d", i));

        // Framing error discards the byte; a short low glitch is ignored.
        send_rx(8'($urandom), 1'b0);
        chk_status("status_frame_err");
        chk_data_pop("frame_err_no_push");
        @(negedge sysclk);
        uart_rxp = 1'b0;
        clocks(3);
        uart_rxp = 1'b1;
        clocks(4 * DIV);
        chk_status("status_after_glitch");
        chk_data_pop("glitch_no_push");

        // CTRL read-back and interrupts.
        wr_reg(16'h0004, 16'hFFFB, lat);
        rd_reg(16'h0004, rd);
        chk("ctrl_mask", 32'(rd), 32'h3);
        wr_reg(16'h0004, 16'h0001, lat);
        clocks(2);
        chk("irq_rx_empty", 32'(irq), 32'd0);
        send_rx(8'($urandom), 1'b1);
        clocks(2);
        chk("irq_rx_valid", 32'(irq), 32'd1);
        chk_data_pop("irq_pop");
        clocks(2);
        chk("irq_cleared", 32'(irq), 32'd0);
        wr_reg(16'h0004, 16'h0002, lat);
        clocks(2);
        chk("irq_txdone", 32'(irq), 32'd1);
        wr_reg(16'h0004, 16'h0000, lat);
        clocks(2);
        chk("irq_off", 32'(irq), 32'd0);

        // Unmapped offsets and addresses.
        rd_reg(16'h0006, rd);
        chk("rd_off6", 32'(rd), 32'hFFFF);
        rd_reg(16'h0012, rd);
        chk("rd_unmapped", 32'(rd), 32'hFFFF);
        wr_reg(16'h0010, 16'h0055, lat);
        wr_reg(16'h0014, 16'h0003, lat);
        rd_reg(16'h0005, rd);
        chk("ctrl_untouched", 32'(rd), 32'h0);
        clocks(3 * DIV);
        chk("unmapped_no_tx", 32'(tx_got.size()), 32'd0);
        chk_status("status_odd_addr");

        // Reset in mid-frame.
        wr_reg(16'h0000, 16'($urandom), lat);
        wr_reg(16'h0000, 16'($urandom), lat);
        send_rx(8'($urandom), 1'b1);
        clocks(3 * DIV);
        @(negedge sysclk);
        reset = 1'b1;
        run = 1'b0;
        @(posedge sysclk); #1;
        chk("midtx_rst_txp", 32'(uart_txp), 32'd1);
        chk("midtx_rst_done", 32'(done), 32'd0);
        @(negedge sysclk);
        reset = 1'b0;
        rx_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        chk_status("status_after_rst");
        clocks(15 * DIV);
        tx_got.delete(); tx_t0.delete(); tx_stop.delete();
        clocks(12 * DIV);
        chk("rst_no_more_tx", 32'(tx_got.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
